lc2k_mc_control: RTL and testbench
==================================

Name: lc2k_mc_control

Overview:
Parametrised multi-cycle control sequencer for the LC2K CPU. It replaces the single-cycle opcode-to-control decode with an FSM that fetches, decodes, executes, accesses memory and writes back over several cycles, using a req/ack handshake to a variable-latency memory. It also adds start/halt/error status, an optional memory-timeout watchdog and optional performance counters. It sits between the datapath (IR, regfile, ALU, PC) and the unified instruction/data memory port.

Parameters:
OPCODE_W, 3, opcode field width; encodings are ADD=0, NOR=1, LW=2, SW=3, BEQ=4, JALR=5, HALT=6, NOOP=7; any value above 7 is treated as NOOP.
MEM_TIMEOUT, 0, maximum cycles to wait for mem_ack; 0 disables the watchdog.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE
opcode  in  OPCODE_W  IR opcode field; valid from DECODE onward
alu_eq  in  1  ALU equality flag (BEQ)
mem_ack  in  1  memory completion, sampled in FETCH/MEM only
mem_req  out  1  memory request; held until ack
mem_we  out  1  1 = write (SW), 0 = read
mem_addr_src  out  1  0 = PC, 1 = ALU result
ir_write  out  1  load IR
alu_srcb  out  1  1 = regB, 0 = sign-extended offset
alu_op  out  2  0 = add, 1 = nor, 2 = eq
reg_we  out  1  register write enable
reg_dst  out  1  1 = destReg, 0 = regB
wb_src  out  2  0 = mem data, 1 = ALU, 2 = PC+1
pc_write  out  1  PC load enable
pc_src  out  2  0 = PC+1, 1 = branch target, 2 = regA (JALR)
retire  out  1  one-cycle pulse per completed instruction
busy  out  1  1 in any state other than IDLE/HALTED/ERROR
halted  out  1  sticky; HALT has executed
error  out  1  sticky; memory timeout
cycle_cnt  out  CNT_W  active cycles (PERF_CNT_EN)
instr_cnt  out  CNT_W  retired instructions (PERF_CNT_EN)

Behaviour:
- Reset (async, rst_n low): state goes to IDLE, op_q=NOOP, timer=0, counters=0. All outputs 0.
- Outputs are a combinational decode of (state, op_q, mem_ack, alu_eq). State, op_q, halted, error and the counters are registered.
- IDLE: start=1 goes to FETCH; otherwise stay.
- FETCH: mem_req=1, mem_addr_src=0, mem_we=0. On mem_ack the same cycle gives ir_write=1 and the next state is DECODE.
- DECODE: latch op_q<=opcode.
  - HALT: retire=1, next state HALTED.
  - NOOP: pc_write=1, pc_src=0, retire=1, next state FETCH.
  - Any other opcode: next state EXEC.
- EXEC: drive alu_srcb/alu_op from op_q (ADD/NOR: regB, op 0/1; LW/SW: offset, add; BEQ: regB, eq).
  - ADD/NOR go to WB. LW/SW go to MEM.
  - BEQ: pc_write=1, pc_src=alu_eq?1:0, retire=1, next state FETCH.
  - JALR: reg_we=1, reg_dst=0, wb_src=2, pc_write=1, pc_src=2, retire=1, next state FETCH. The datapath holds the regA value read earlier, so regA==regB is safe.
- MEM: mem_req=1, mem_addr_src=1, mem_we=(op_q==SW). Held until mem_ack.
  - SW on ack: pc_write=1, pc_src=0, retire=1, next state FETCH.
  - LW on ack: next state WB.
- WB: reg_we=1, pc_write=1, pc_src=0, retire=1, next state FETCH.
  - ADD/NOR: reg_dst=1, wb_src=1.
  - LW: reg_dst=0, wb_src=0.
- HALTED and ERROR are terminal until reset; start is ignored there.
- start while busy is ignored. mem_ack outside FETCH/MEM is ignored.
- Watchdog (MEM_TIMEOUT>0): the timer counts cycles in FETCH/MEM with mem_ack=0 and clears on ack or on state change. When it reaches MEM_TIMEOUT, the next state is ERROR, error=1 and mem_req drops. An ack arriving in that same cycle wins.
- Minimum latency with ack in the first cycle: ADD/NOR 4 cycles, LW 5, SW 4, BEQ/JALR 3, NOOP/HALT 2.

Optional Feature:
PERF_CNT_EN.
- Defined: cycle_cnt increments every cycle busy=1; instr_cnt increments on retire. Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built. The port list is unchanged.

Decomposition:
- Package lc2k_pkg holds:
  - opcode constants OP_ADD..OP_NOOP
  - state enum IDLE/FETCH/DECODE/EXEC/MEM/WB/HALTED/ERROR
  - encodings for alu_op, wb_src and pc_src
- One sub-module, lc2k_mem_watchdog: parameter MEM_TIMEOUT; inputs clk, rst_n, waiting, ack; output expired. It uses a $clog2(MEM_TIMEOUT+1)-bit counter.

Test Plan:
- ADD, ack immediate: start gives FETCH, DECODE, EXEC, WB. reg_we=1, reg_dst=1, wb_src=1 and retire in cycle 4; instr_cnt=1.
- LW, ack delayed 2 cycles in MEM: mem_req held 3 cycles with mem_addr_src=1, mem_we=0. WB has wb_src=0, reg_dst=0. Total 7 cycles.
- BEQ with alu_eq=1 then alu_eq=0: pc_src=1, then pc_src=0, each with pc_write=1 in EXEC. No reg_we.
- JALR: EXEC has reg_we=1, wb_src=2, pc_src=2, pc_write=1 together.
- HALT then start pulses: halted=1, busy=0, no further mem_req. cycle_cnt frozen.
- MEM_TIMEOUT=4, no ack in FETCH: error=1 after 4 cycles and mem_req=0. Separately, a rst_n pulse mid-MEM gives IDLE with all outputs 0 immediately.

Source files
------------

// File: rtl/lc2k_pkg.sv
// Shared encodings for the LC2K multi-cycle control sequencer: opcodes,
// FSM states and the datapath mux-select values.
package lc2k_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_NOOP = 3'd7;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_NOR = 2'd1;
    localparam logic [1:0] ALU_EQ  = 2'd2;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC1 = 2'd2;

    localparam logic [1:0] PC_PLUS1  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_REGA   = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED,
        ERROR
    } state_t;

endpackage

// File: rtl/lc2k_mem_watchdog.sv
// Counts consecutive cycles a memory request goes unacknowledged and flags
// the cycle in which the wait would reach MEM_TIMEOUT.
module lc2k_mem_watchdog #(
    parameter int MEM_TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic ack,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;
    logic         stalled;

    assign stalled = waiting && !ack;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (stalled) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

    // An ack in the would-be expiry cycle suppresses the timeout.
    assign expired = stalled && (count == LAST);

endmodule

// File: rtl/lc2k_mc_control.sv
// Multi-cycle FSM sequencer for the LC2K datapath with req/ack memory port.
// Optional performance counters are built when PERF_CNT_EN is defined.
module lc2k_mc_control
    import lc2k_pkg::*;
#(
    parameter int OPCODE_W    = 3,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_eq,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_src,
    output logic                ir_write,
    output logic                alu_srcb,
    output logic [1:0]          alu_op,
    output logic                reg_we,
    output logic                reg_dst,
    output logic [1:0]          wb_src,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                retire,
    output logic                busy,
    output logic                halted,
    output logic                error,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
);

    state_t     state, state_next;
    logic [2:0] op_q;
    logic [2:0] op_in;
    logic       wd_expired;

    generate
        if (OPCODE_W > 3) begin : g_wide_op
            assign op_in = (|opcode[OPCODE_W-1:3]) ? OP_NOOP : opcode[2:0];
        end else begin : g_narrow_op
            assign op_in = opcode[2:0];
        end
    endgenerate

    generate
        if (MEM_TIMEOUT > 0) begin : g_wd
            logic mem_wait;
            assign mem_wait = (state == FETCH) || (state == MEM);
            lc2k_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
                .clk     (clk),
                .rst_n   (rst_n),
                .waiting (mem_wait),
                .ack     (mem_ack),
                .expired (wd_expired)
            );
        end else begin : g_no_wd
            assign wd_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= OP_NOOP;
            halted <= 1'b0;
            error  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DECODE) op_q <= op_in;
            if (state_next == HALTED) halted <= 1'b1;
            if (state_next == ERROR) error <= 1'b1;
        end
    end

    assign busy = !(state inside {IDLE, HALTED, ERROR});

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        ir_write     = 1'b0;
        alu_srcb     = 1'b0;
        alu_op       = ALU_ADD;
        reg_we       = 1'b0;
        reg_dst      = 1'b0;
        wb_src       = WB_MEM;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS1;
        retire       = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write   = 1'b1;
                    state_next = DECODE;
                end else if (wd_expired) begin
                    state_next = ERROR;
                end
            end
            DECODE: begin
                // The IR is loaded by now, so decode from the live opcode.
                case (op_in)
                    OP_HALT: begin
                        retire     = 1'b1;
                        state_next = HALTED;
                    end
                    OP_NOOP: begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    default: state_next = EXEC;
                endcase
            end
            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        alu_srcb   = 1'b1;
                        state_next = WB;
                    end
                    OP_NOR: begin
                        alu_srcb   = 1'b1;
                        alu_op     = ALU_NOR;
                        state_next = WB;
                    end
                    OP_LW, OP_SW: state_next = MEM;
                    OP_BEQ: begin
                        alu_srcb   = 1'b1;
                        alu_op     = ALU_EQ;
                        pc_write   = 1'b1;
                        pc_src     = alu_eq ? PC_BRANCH : PC_PLUS1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    OP_JALR: begin
                        reg_we     = 1'b1;
                        wb_src     = WB_PC1;
                        pc_write   = 1'b1;
                        pc_src     = PC_REGA;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    default: state_next = FETCH;
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = (op_q == OP_SW);
                if (mem_ack) begin
                    if (op_q == OP_SW) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (wd_expired) begin
                    state_next = ERROR;
                end
            end
            WB: begin
                reg_we     = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
                if (op_q != OP_LW) begin
                    reg_dst = 1'b1;
                    wb_src  = WB_ALU;
                end
            end
            HALTED, ERROR: state_next = state;
            default: state_next = IDLE;
        endcase
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (busy && !(&cycle_q)) cycle_q <= cycle_q + 1'b1;
            if (retire && !(&instr_q)) instr_q <= instr_q + 1'b1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_lc2k_mc_control.sv
// Directed bench for lc2k_mc_control (MEM_TIMEOUT=4); expected control
// vectors go through a scoreboard queue and are checked at each negedge.
module tb_lc2k_mc_control;
    import lc2k_pkg::*;

    localparam int CNT_W = 32;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       opcode = 3'd0;
    logic             alu_eq = 1'b0;
    logic             mem_ack = 1'b0;
    logic             mem_req, mem_we, mem_addr_src, ir_write, alu_srcb;
    logic [1:0]       alu_op, wb_src, pc_src;
    logic             reg_we, reg_dst, pc_write, retire, busy, halted, error;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    lc2k_mc_control #(.OPCODE_W(3), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .alu_eq(alu_eq), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_src(mem_addr_src), .ir_write(ir_write),
        .alu_srcb(alu_srcb), .alu_op(alu_op), .reg_we(reg_we),
        .reg_dst(reg_dst), .wb_src(wb_src), .pc_write(pc_write),
        .pc_src(pc_src), .retire(retire), .busy(busy), .halted(halted),
        .error(error), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_src;
        logic       ir_write;
        logic       alu_srcb;
        logic [1:0] alu_op;
        logic       reg_we;
        logic       reg_dst;
        logic [1:0] wb_src;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       retire;
        logic       busy;
        logic       halted;
        logic       error;
    } ctrl_t;

    ctrl_t            exp_q[$];
    int               errors = 0;
    int               checks = 0;
    logic [CNT_W-1:0] m_cycles = '0;
    logic [CNT_W-1:0] m_instr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ctrl_t observed();
        ctrl_t c;
        c.mem_req = mem_req;   c.mem_we = mem_we;     c.mem_addr_src = mem_addr_src;
        c.ir_write = ir_write; c.alu_srcb = alu_srcb; c.alu_op = alu_op;
        c.reg_we = reg_we;     c.reg_dst = reg_dst;   c.wb_src = wb_src;
        c.pc_write = pc_write; c.pc_src = pc_src;     c.retire = retire;
        c.busy = busy;         c.halted = halted;     c.error = error;
        return c;
    endfunction

    function automatic ctrl_t c_fetch(input logic ack);
        ctrl_t c = '0;
        c.busy = 1'b1; c.mem_req = 1'b1; c.ir_write = ack;
        return c;
    endfunction

    function automatic ctrl_t c_decode(input logic [2:0] op);
        ctrl_t c = '0;
        c.busy = 1'b1;
        if (op == OP_HALT) c.retire = 1'b1;
        if (op == OP_NOOP) begin c.pc_write = 1'b1; c.retire = 1'b1; end
        return c;
    endfunction

    function automatic ctrl_t c_exec(input logic [2:0] op, input logic eq);
        ctrl_t c = '0;
        c.busy = 1'b1;
        case (op)
            OP_ADD:  c.alu_srcb = 1'b1;
            OP_NOR:  begin c.alu_srcb = 1'b1; c.alu_op = 2'd1; end
            OP_BEQ:  begin
                c.alu_srcb = 1'b1; c.alu_op = 2'd2; c.pc_write = 1'b1;
                c.pc_src = eq ? 2'd1 : 2'd0; c.retire = 1'b1;
            end
            OP_JALR: begin
                c.reg_we = 1'b1; c.wb_src = 2'd2; c.pc_write = 1'b1;
                c.pc_src = 2'd2; c.retire = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t c_mem(input logic [2:0] op, input logic ack);
        ctrl_t c = '0;
        c.busy = 1'b1; c.mem_req = 1'b1; c.mem_addr_src = 1'b1;
        c.mem_we = (op == OP_SW);
        if (ack && op == OP_SW) begin c.pc_write = 1'b1; c.retire = 1'b1; end
        return c;
    endfunction

    function automatic ctrl_t c_wb(input logic [2:0] op);
        ctrl_t c = '0;
        c.busy = 1'b1; c.reg_we = 1'b1; c.pc_write = 1'b1; c.retire = 1'b1;
        if (op != OP_LW) begin c.reg_dst = 1'b1; c.wb_src = 2'd1; end
        return c;
    endfunction

    function automatic ctrl_t c_term(input logic h, input logic e);
        ctrl_t c = '0;
        c.halted = h; c.error = e;
        return c;
    endfunction

    // One clock: drive inputs, queue the expected vector, compare at negedge.
    task automatic cyc(input string tag, input logic s, input logic [2:0] op,
                       input logic ack, input logic eq, input ctrl_t e);
        ctrl_t want;
        start = s; opcode = op; mem_ack = ack; alu_eq = eq;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        check(tag, 64'(observed()), 64'(want));
        check({tag, ".cycle_cnt"}, 64'(cycle_cnt), PERF ? 64'(m_cycles) : 64'd0);
        check({tag, ".instr_cnt"}, 64'(instr_cnt), PERF ? 64'(m_instr) : 64'd0);
        if (want.busy) m_cycles++;
        if (want.retire) m_instr++;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; opcode is scrambled outside
    // DECODE and ack/start are noisy where they must be ignored.
    task automatic instr(input string tag, input logic [2:0] op, input logic eq,
                         input int fetch_wait, input int mem_wait);
        for (int i = 0; i < fetch_wait; i++)
            cyc({tag, ".fetch_wait"}, 1'b0, ~op, 1'b0, eq, c_fetch(1'b0));
        cyc({tag, ".fetch"}, 1'b1, ~op, 1'b1, eq, c_fetch(1'b1));
        cyc({tag, ".decode"}, 1'b1, op, 1'b1, eq, c_decode(op));
        if (op != OP_HALT && op != OP_NOOP) begin
            cyc({tag, ".exec"}, 1'b1, ~op, 1'b1, eq, c_exec(op, eq));
            if (op == OP_LW || op == OP_SW) begin
                for (int i = 0; i < mem_wait; i++)
                    cyc({tag, ".mem_wait"}, 1'b0, ~op, 1'b0, eq, c_mem(op, 1'b0));
                cyc({tag, ".mem"}, 1'b0, ~op, 1'b1, eq, c_mem(op, 1'b1));
            end
            if (op == OP_ADD || op == OP_NOR || op == OP_LW)
                cyc({tag, ".wb"}, 1'b1, ~op, 1'b1, eq, c_wb(op));
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0;
        #3;
        check(tag, 64'(observed()), 64'd0);
        check({tag, ".cycle_cnt"}, 64'(cycle_cnt), 64'd0);
        check({tag, ".instr_cnt"}, 64'(instr_cnt), 64'd0);
        m_cycles = '0;
        m_instr = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #12;
        check("reset", 64'(observed()), 64'd0);
        check("reset.cycle_cnt", 64'(cycle_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc("idle", 1'b0, OP_ADD, 1'b1, 1'b0, c_term(1'b0, 1'b0));
        cyc("start", 1'b1, OP_ADD, 1'b0, 1'b0, c_term(1'b0, 1'b0));
        instr("add", OP_ADD, 1'b0, 0, 0);
        instr("nor", OP_NOR, 1'b0, 1, 0);
        instr("lw", OP_LW, 1'b0, 0, 2);
        instr("sw", OP_SW, 1'b0, 0, 0);
        instr("beq_taken", OP_BEQ, 1'b1, 0, 0);
        instr("beq_not", OP_BEQ, 1'b0, 0, 0);
        instr("jalr", OP_JALR, 1'b1, 0, 0);
        instr("noop", OP_NOOP, 1'b0, 0, 0);
        instr("fetch_ack_wins", OP_NOOP, 1'b0, 3, 0);
        instr("mem_ack_wins", OP_LW, 1'b0, 0, 3);

        // Asynchronous reset in the middle of an SW memory access.
        cyc("sw2.fetch", 1'b0, OP_ADD, 1'b1, 1'b0, c_fetch(1'b1));
        cyc("sw2.decode", 1'b0, OP_SW, 1'b0, 1'b0, c_decode(OP_SW));
        cyc("sw2.exec", 1'b0, OP_SW, 1'b0, 1'b0, c_exec(OP_SW, 1'b0));
        check("sw2.mem_pre_reset", 64'(observed()), 64'(c_mem(OP_SW, 1'b0)));
        #2;
        do_reset("mid_mem_reset");
        cyc("post_reset_idle", 1'b0, OP_ADD, 1'b0, 1'b0, c_term(1'b0, 1'b0));

        // HALT, then start pulses must not restart anything.
        cyc("start_halt", 1'b1, OP_ADD, 1'b0, 1'b0, c_term(1'b0, 1'b0));
        instr("halt", OP_HALT, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("halted", 1'b1, OP_ADD, 1'b1, 1'b0, c_term(1'b1, 1'b0));

        // Fetch watchdog: four unacknowledged cycles then ERROR.
        do_reset("reset_from_halt");
        cyc("start_wd", 1'b1, OP_ADD, 1'b0, 1'b0, c_term(1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            cyc("wd_fetch", 1'b0, OP_ADD, 1'b0, 1'b0, c_fetch(1'b0));
        for (int i = 0; i < 2; i++)
            cyc("error", 1'b1, OP_ADD, 1'b1, 1'b0, c_term(1'b0, 1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
